// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: hazard FSM states, register-file
// address width and the load-use hazard compare.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  // True when the load in EX writes a register the ID instruction reads.
  // x0 is never a real dependency, so a load targeting it never stalls.
  function automatic logic lu_hazard(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic                  use_rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  use_rs2
  );
    return mem_read && (rd != REG_ZERO) &&
           (((rd == rs1) && use_rs1) || ((rd == rs2) && use_rs2));
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-unit signal bundle: pipeline status in, stall/flush controls out.
// Optional HAZARD_PERF_EN adds three 32-bit performance counters.
interface hazard_unit_if;
  import pipe_pkg::*;

  logic [REG_ADDR_W-1:0] IF_ID_rs1;
  logic [REG_ADDR_W-1:0] IF_ID_rs2;
  logic                  IF_ID_use_rs1;
  logic                  IF_ID_use_rs2;
  logic                  ID_EX_MemRead;
  logic [REG_ADDR_W-1:0] ID_EX_rd;
  logic                  EX_MEM_Branch_taken;
  logic                  EX_MEM_MemAccess;
  logic                  dmem_ready;

  logic                  PC_Write;
  logic                  IF_ID_Write;
  logic                  IF_ID_Flush;
  logic                  CTRL_SELECT;
  logic                  EX_MEM_Flush;
  logic                  Pipe_Freeze;
  logic                  mem_timeout_err;
`ifdef HAZARD_PERF_EN
  logic [31:0]           perf_lu_cnt;
  logic [31:0]           perf_flush_cnt;
  logic [31:0]           perf_mem_cnt;
`endif

  // Pipeline side: supplies status, consumes controls.
  modport master (
    output IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2,
    output ID_EX_MemRead, ID_EX_rd, EX_MEM_Branch_taken,
    output EX_MEM_MemAccess, dmem_ready,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, CTRL_SELECT,
    input  EX_MEM_Flush, Pipe_Freeze, mem_timeout_err
`ifdef HAZARD_PERF_EN
    , input perf_lu_cnt, perf_flush_cnt, perf_mem_cnt
`endif
  );

  // Hazard unit side.
  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2,
    input  ID_EX_MemRead, ID_EX_rd, EX_MEM_Branch_taken,
    input  EX_MEM_MemAccess, dmem_ready,
    output PC_Write, IF_ID_Write, IF_ID_Flush, CTRL_SELECT,
    output EX_MEM_Flush, Pipe_Freeze, mem_timeout_err
`ifdef HAZARD_PERF_EN
    , output perf_lu_cnt, perf_flush_cnt, perf_mem_cnt
`endif
  );

endinterface

// File: rtl/hazard_watchdog.sv
// Data-memory wait watchdog: counts consecutive wait cycles (saturating)
// and raises a sticky error once the wait reaches MEM_TIMEOUT cycles.
module hazard_watchdog #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rstn,
  input  logic wait_active,
  output logic mem_timeout_err
);

  localparam logic [7:0] TO_MAX  = 8'(MEM_TIMEOUT);
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] to_cnt_q, to_cnt_d;
  logic       err_q, err_d;

  // Count while the pipe is frozen on memory; any non-wait cycle clears.
  always_comb begin
    to_cnt_d = 8'd0;
    err_d    = err_q;
    if (wait_active) begin
      to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 8'd1;
      if (to_cnt_q == TO_LAST) begin
        err_d = 1'b1;
      end
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign mem_timeout_err = err_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// data-memory wait freezes (priority: memory wait, branch, load-use).
// Outputs are combinational from state and inputs.
// Define HAZARD_PERF_EN to add bubble/flush/mem-wait performance counters.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rstn,
  hazard_unit_if.slave  hz
);

  localparam logic [1:0] LU_BUB_M1 = 2'(LU_BUBBLES - 1);

  hz_state_t  state_q, state_d;
  logic [1:0] bub_cnt_q, bub_cnt_d;

  logic lu_hit;
  logic mem_wait;
  logic pc_write, ifid_write, ifid_flush, ctrl_sel, exmem_flush, freeze;
  logic lu_bubble;

  assign lu_hit = lu_hazard(hz.ID_EX_MemRead, hz.ID_EX_rd,
                            hz.IF_ID_rs1, hz.IF_ID_use_rs1,
                            hz.IF_ID_rs2, hz.IF_ID_use_rs2);

  // Once waiting, only dmem_ready releases the freeze; from RUN/LU_STALL a
  // wait starts when an access in MEM is not completed this cycle.
  assign mem_wait = (state_q == MEM_WAIT) ? !hz.dmem_ready
                                          : (hz.EX_MEM_MemAccess && !hz.dmem_ready);

  // Next-state and control decode in priority order.
  always_comb begin
    state_d     = state_q;
    bub_cnt_d   = bub_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    ctrl_sel    = 1'b1;
    exmem_flush = 1'b0;
    freeze      = 1'b0;
    lu_bubble   = 1'b0;
    if (mem_wait) begin
      // Hold everything; ID/EX is frozen rather than bubbled.
      state_d    = MEM_WAIT;
      bub_cnt_d  = 2'd0;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      freeze     = 1'b1;
    end else if (hz.EX_MEM_Branch_taken) begin
      // Squash the wrong-path instructions; PC still loads the target.
      state_d     = RUN;
      bub_cnt_d   = 2'd0;
      ifid_flush  = 1'b1;
      exmem_flush = 1'b1;
      ctrl_sel    = 1'b0;
    end else if (state_q == LU_STALL) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ctrl_sel   = 1'b0;
      lu_bubble  = 1'b1;
      bub_cnt_d  = bub_cnt_q - 2'd1;
      if (bub_cnt_q <= 2'd1) begin
        state_d = RUN;
      end
    end else if (lu_hit) begin
      // Detection cycle is the first bubble.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ctrl_sel   = 1'b0;
      lu_bubble  = 1'b1;
      bub_cnt_d  = LU_BUB_M1;
      state_d    = (LU_BUBBLES > 1) ? LU_STALL : RUN;
    end else begin
      state_d = RUN;
    end
  end

  // FSM state and bubble counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= RUN;
      bub_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      bub_cnt_q <= bub_cnt_d;
    end
  end

  hazard_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk             (clk),
    .rstn            (rstn),
    .wait_active     (mem_wait),
    .mem_timeout_err (hz.mem_timeout_err)
  );

  // While reset is held the pipeline sees plain RUN controls regardless
  // of what the status inputs are doing.
  assign hz.PC_Write     = pc_write   | !rstn;
  assign hz.IF_ID_Write  = ifid_write | !rstn;
  assign hz.CTRL_SELECT  = ctrl_sel   | !rstn;
  assign hz.IF_ID_Flush  = ifid_flush  & rstn;
  assign hz.EX_MEM_Flush = exmem_flush & rstn;
  assign hz.Pipe_Freeze  = freeze      & rstn;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_lu_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_mem_q, perf_mem_d;

  // Free-running event counters, wrapping at 2^32.
  always_comb begin
    perf_lu_d    = perf_lu_q    + {31'd0, lu_bubble};
    perf_flush_d = perf_flush_q + {31'd0, ifid_flush};
    perf_mem_d   = perf_mem_q   + {31'd0, freeze};
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_lu_q    <= 32'd0;
      perf_flush_q <= 32'd0;
      perf_mem_q   <= 32'd0;
    end else begin
      perf_lu_q    <= perf_lu_d;
      perf_flush_q <= perf_flush_d;
      perf_mem_q   <= perf_mem_d;
    end
  end

  assign hz.perf_lu_cnt    = perf_lu_q;
  assign hz.perf_flush_cnt = perf_flush_q;
  assign hz.perf_mem_cnt   = perf_mem_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: two instances (1 and 3 load-use bubbles)
// share one stimulus stream; controls are checked each cycle at negedge.
module tb_hazard_unit;

  // Packed view: {PC_Write, IF_ID_Write, IF_ID_Flush, CTRL_SELECT,
  //               EX_MEM_Flush, Pipe_Freeze, mem_timeout_err}
  localparam logic [6:0] RUN_V  = 7'b1101000;
  localparam logic [6:0] BUB_V  = 7'b0000000;
  localparam logic [6:0] FLU_V  = 7'b1110100;
  localparam logic [6:0] WAIT_V = 7'b0001010;
  localparam logic [6:0] ERR_V  = 7'b0000001;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] rs1, rs2, rd;
  logic       use1, use2, mem_read, br, macc, rdy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit_if ifa ();
  hazard_unit_if ifb ();

  assign ifa.IF_ID_rs1 = rs1;            assign ifb.IF_ID_rs1 = rs1;
  assign ifa.IF_ID_rs2 = rs2;            assign ifb.IF_ID_rs2 = rs2;
  assign ifa.IF_ID_use_rs1 = use1;       assign ifb.IF_ID_use_rs1 = use1;
  assign ifa.IF_ID_use_rs2 = use2;       assign ifb.IF_ID_use_rs2 = use2;
  assign ifa.ID_EX_MemRead = mem_read;   assign ifb.ID_EX_MemRead = mem_read;
  assign ifa.ID_EX_rd = rd;              assign ifb.ID_EX_rd = rd;
  assign ifa.EX_MEM_Branch_taken = br;   assign ifb.EX_MEM_Branch_taken = br;
  assign ifa.EX_MEM_MemAccess = macc;    assign ifb.EX_MEM_MemAccess = macc;
  assign ifa.dmem_ready = rdy;           assign ifb.dmem_ready = rdy;

  hazard_unit #(.LU_BUBBLES(1), .MEM_TIMEOUT(15)) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .hz   (ifa)
  );

  hazard_unit #(.LU_BUBBLES(3), .MEM_TIMEOUT(15)) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .hz   (ifb)
  );

  logic [6:0] oa, ob;
  assign oa = {ifa.PC_Write, ifa.IF_ID_Write, ifa.IF_ID_Flush, ifa.CTRL_SELECT,
               ifa.EX_MEM_Flush, ifa.Pipe_Freeze, ifa.mem_timeout_err};
  assign ob = {ifb.PC_Write, ifb.IF_ID_Write, ifb.IF_ID_Flush, ifb.CTRL_SELECT,
               ifb.EX_MEM_Flush, ifb.Pipe_Freeze, ifb.mem_timeout_err};

  task automatic set_in(input logic mr, input logic [4:0] d,
                        input logic [4:0] s1, input logic u1,
                        input logic [4:0] s2, input logic u2,
                        input logic b, input logic ma, input logic ry);
    mem_read = mr; rd = d; rs1 = s1; use1 = u1; rs2 = s2; use2 = u2;
    br = b; macc = ma; rdy = ry;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One transaction line, then check both instances.
  task automatic chk2(input string tag, input logic [6:0] exp_a, input logic [6:0] exp_b);
    $display("t=%0t %s: a=%b b=%b", $time, tag, oa, ob);
    chk({tag, "_a"}, oa, exp_a);
    chk({tag, "_b"}, ob, exp_b);
  endtask

  initial begin
    // Reset held with a live load-use pattern on the inputs.
    rstn = 1'b0;
    set_in(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk2("reset", RUN_V, RUN_V);
    #2;
    idle();
    rstn = 1'b1;
    tick();

    @(negedge clk); chk2("idle", RUN_V, RUN_V); tick();

    // lw x5 in EX, ID reads x5 as rs2: 1 bubble on a, 3 bubbles on b.
    set_in(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk2("lu_c1", BUB_V, BUB_V); tick();
    idle();
    @(negedge clk); chk2("lu_c2", RUN_V, BUB_V); tick();
    @(negedge clk); chk2("lu_c3", RUN_V, BUB_V); tick();
    @(negedge clk); chk2("lu_c4", RUN_V, RUN_V); tick();

    // Load-use via rs1, then a taken branch in bubble 2 cuts the stall.
    set_in(1'b1, 5'd9, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk2("lubr_c1", BUB_V, BUB_V); tick();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk); chk2("lubr_c2", FLU_V, FLU_V); tick();
    idle();
    @(negedge clk); chk2("lubr_c3", RUN_V, RUN_V); tick();

    // Load to x0 never stalls; an unused matching source never stalls.
    set_in(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk2("rd_zero", RUN_V, RUN_V); tick();
    set_in(1'b1, 5'd7, 5'd7, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk2("no_use", RUN_V, RUN_V); tick();

    // Branch concurrent with load-use: the flush wins, for one cycle only.
    set_in(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk); chk2("br_lu", FLU_V, FLU_V); tick();
    idle();
    @(negedge clk); chk2("br_after", RUN_V, RUN_V); tick();

    // Memory wait of 4 cycles (branch during the wait is ignored).
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, (i == 3), 1'b1, 1'b0);
      @(negedge clk); chk2($sformatf("mw4_c%0d", i), WAIT_V, WAIT_V); tick();
    end
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk); chk2("mw4_ready", RUN_V, RUN_V); tick();
    idle();
    @(negedge clk); chk2("mw4_idle", RUN_V, RUN_V); tick();

    // Long wait: error flag appears from the 16th wait cycle on.
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk2($sformatf("tmo_c%0d", i), (i > 15) ? (WAIT_V | ERR_V) : WAIT_V,
                                      (i > 15) ? (WAIT_V | ERR_V) : WAIT_V);
      tick();
    end
    // Ready releases the freeze but the flag is sticky.
    rdy = 1'b1;
    @(negedge clk); chk2("tmo_ready", RUN_V | ERR_V, RUN_V | ERR_V); tick();
    // New wait, then reset mid-wait: RUN controls and flag cleared at once.
    rdy = 1'b0;
    @(negedge clk); chk2("tmo_rewait", WAIT_V | ERR_V, WAIT_V | ERR_V);
    #2;
    rstn = 1'b0;
    #1;
    chk2("rst_midwait", RUN_V, RUN_V);
    tick();
    idle();
    rstn = 1'b1;
    @(negedge clk); chk2("post_reset", RUN_V, RUN_V); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
